// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle, 32-step fixed latency.
// Results land in hi (remainder) and lo (quotient) and hold until the next completion.
module div_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        annul,
  output logic        busy,
  output logic        ready,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [32:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic [31:0] a_q, a_d;
  logic        negq_q, negq_d;
  logic        negr_q, negr_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        load;
  logic        step;
  logic [33:0] trial;
  logic [32:0] step_rem;
  logic [31:0] step_quo;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      count_q <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      a_q     <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      a_q     <= a_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Annul blocks a new request only from IDLE; a committed DONE cycle may still chain one.
  assign load = start && (((state_q == IDLE) && !annul) || (state_q == DONE));
  assign step = (state_q == RUN) && !annul;

  always_comb begin
    // NOTE: default every combinational output first so no path can infer a latch.
    state_d = state_q;
    case (state_q)
      IDLE:    if (load) state_d = RUN;
      RUN:     if (annul) state_d = IDLE;
               else if (count_q == 5'd31) state_d = DONE;
      DONE:    state_d = load ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The quotient register doubles as the dividend shifter: dividend bits leave at the top
  // as quotient bits enter at the bottom.
  always_comb begin
    trial    = {1'b0, rem_q[31:0], quo_q[31]} - {2'b00, dvsr_q};
    step_rem = trial[33] ? {rem_q[31:0], quo_q[31]} : trial[32:0];
    step_quo = {quo_q[30:0], ~trial[33]};
  end

  always_comb begin
    count_d = count_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    a_d     = a_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (load) begin
      count_d = '0;
      rem_d   = '0;
      a_d     = a;
      quo_d   = (signed_div && a[31]) ? -a : a;
      dvsr_d  = (signed_div && b[31]) ? -b : b;
      negq_d  = signed_div && (a[31] ^ b[31]);
      negr_d  = signed_div && a[31];
    end else if (step) begin
      count_d = count_q + 5'd1;
      rem_d   = step_rem;
      quo_d   = step_quo;
      if (count_q == 5'd31) begin
        // Divide by zero bypasses the sign fixup so hi returns the raw dividend.
        if (dvsr_q == '0) begin
          hi_d = a_q;
          lo_d = '1;
        end else begin
          hi_d = negr_q ? -step_rem[31:0] : step_rem[31:0];
          lo_d = negq_q ? -step_quo : step_quo;
        end
      end
    end
  end

  always_comb begin
    busy  = (state_q == RUN);
    ready = (state_q == DONE);
    hi    = hi_q;
    lo    = lo_q;
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed and random checks of div_unit against an arithmetic reference model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        signed_div;
  logic [31:0] a;
  logic [31:0] b;
  logic        annul;
  logic        busy;
  logic        ready;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;

  div_unit dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .signed_div (signed_div),
    .a          (a),
    .b          (b),
    .annul      (annul),
    .busy       (busy),
    .ready      (ready),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [31:0] av, input logic [31:0] bv, input logic sv,
                                output logic [31:0] eh, output logic [31:0] el);
    int sa, sb;
    sa = av;
    sb = bv;
    if (bv == 32'd0) begin
      eh = av;
      el = 32'hFFFF_FFFF;
    end else if (sv && av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
      eh = 32'd0;
      el = 32'h8000_0000;
    end else if (sv) begin
      el = sa / sb;
      eh = sa % sb;
    end else begin
      el = av / bv;
      eh = av % bv;
    end
  endfunction

  // Starts from the sample just after the accepting edge; stops at the sample showing ready.
  task automatic wait_ready(output int bc, output bit got);
    bc  = 0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (ready) got = 1'b1;
      else begin
        if (busy) bc++;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic run_div(input logic [31:0] av, input logic [31:0] bv, input logic sv,
                         input string tag);
    logic [31:0] eh, el;
    int bc;
    bit got;
    model(av, bv, sv, eh, el);
    a = av; b = bv; signed_div = sv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; signed_div = ~sv;
    wait_ready(bc, got);
    chk({tag, "_ready"}, 32'(got), 32'd1);
    chk({tag, "_busycnt"}, 32'(bc), 32'd32);
    chk({tag, "_lo"}, lo, el);
    chk({tag, "_hi"}, hi, eh);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, 32'(ready), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [31:0] ph, pl, ra, rb;
    int bc;
    bit got;

    resetn = 1'b0; start = 1'b0; signed_div = 1'b0; a = '0; b = '0; annul = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;

    run_div(32'd100, 32'd7, 1'b0, "udiv");
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, "sdiv_neg_a");
    chk("sdiv_neg_a_lit_lo", lo, 32'hFFFF_FFFD);
    chk("sdiv_neg_a_lit_hi", hi, 32'hFFFF_FFFF);
    run_div(32'd7, 32'hFFFF_FFFE, 1'b1, "sdiv_neg_b");
    chk("sdiv_neg_b_lit_hi", hi, 32'd1);
    run_div(32'h1234_5678, 32'd0, 1'b0, "udiv_zero");
    run_div(32'h1234_5678, 32'd0, 1'b1, "sdiv_zero");
    run_div(32'hF234_5678, 32'd0, 1'b1, "sdiv_zero_neg");
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "sdiv_ovf");
    run_div(32'hFFFF_FFFF, 32'd1, 1'b0, "udiv_max");

    // Annul in RUN cycle 10.
    ph = hi; pl = lo;
    a = 32'd1000; b = 32'd3; signed_div = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    chk("annul_still_busy", 32'(busy), 32'd1);
    annul = 1'b1;
    @(posedge clk); #1;
    annul = 1'b0;
    chk("annul_busy", 32'(busy), 32'd0);
    chk("annul_ready", 32'(ready), 32'd0);
    repeat (2) begin @(posedge clk); #1; end
    chk("annul_ready_late", 32'(ready), 32'd0);
    chk("annul_hi", hi, ph);
    chk("annul_lo", lo, pl);
    run_div(32'd1000, 32'd3, 1'b0, "after_annul");

    // Back-to-back: second request held in the DONE cycle.
    a = 32'd9; b = 32'd4; signed_div = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_ready(bc, got);
    chk("b2b_first_ready", 32'(got), 32'd1);
    chk("b2b_first_lo", lo, 32'd2);
    chk("b2b_first_hi", hi, 32'd1);
    a = 32'd50; b = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_busy_again", 32'(busy), 32'd1);
    chk("b2b_no_ready", 32'(ready), 32'd0);
    wait_ready(bc, got);
    chk("b2b_second_ready", 32'(got), 32'd1);
    chk("b2b_second_busycnt", 32'(bc), 32'd32);
    chk("b2b_second_lo", lo, 32'd10);
    chk("b2b_second_hi", hi, 32'd0);
    @(posedge clk); #1;

    // start during RUN with other operands is ignored.
    a = 32'd12345; b = 32'd67; signed_div = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 32'd77; b = 32'd5; start = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    start = 1'b0;
    wait_ready(bc, got);
    chk("ign_ready", 32'(got), 32'd1);
    chk("ign_lo", lo, 32'd184);
    chk("ign_hi", hi, 32'd17);
    @(posedge clk); #1;

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = (i % 3 == 0) ? ($urandom & 32'hFF) : $urandom;
      if (i % 4 == 1) rb = rb >> ($urandom % 32);
      run_div(ra, rb, 1'($urandom), $sformatf("rand%0d", i));
    end

    // Asynchronous reset in the middle of RUN.
    a = 32'd999; b = 32'd10; signed_div = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(ready), 32'd0);
    chk("mid_rst_hi", hi, 32'd0);
    chk("mid_rst_lo", lo, 32'd0);
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle", 32'(busy), 32'd0);
    run_div(32'd999, 32'd10, 1'b0, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
